// File: rtl/snes_bus_pkg.sv
// Shared constants and address decode for the SNES bus conditioning block.
// Pure definitions; no logic, no latency.
package snes_bus_pkg;

  localparam int          FILT_LEN_DEFAULT = 3;
  localparam logic [15:0] PAD_LATCH_ADDR   = 16'h4016;
  localparam logic [23:0] NMI_VEC_LO       = 24'h00FFEA;

  // Banks $00-$3F and $80-$BF are exactly those with bit 6 clear.
  function automatic logic is_lowbank(input logic [7:0] bank);
    return ~bank[6];
  endfunction

endpackage

// File: rtl/snes_bus_sync_if.sv
// Raw SNES cartridge-bus pins plus the conditioned strobes derived from them.
// The master drives the pins; the slave is the conditioning stage.
interface snes_bus_sync_if;

  logic        SNES_CPU_CLK_in;
  logic        SNES_READ_in;
  logic        SNES_WRITE_in;
  logic        SNES_PARD_in;
  logic        SNES_PAWR_in;
  logic        SNES_RESET_in;
  logic [23:0] SNES_ADDR;
  logic [7:0]  SNES_DATA;

  logic        SNES_cycle_start;
  logic        SNES_rd_strobe;
  logic        SNES_wr_strobe;
  logic        SNES_wr_end;
  logic        SNES_pard_strobe;
  logic        SNES_pawr_strobe;
  logic        SNES_reset_strobe;
  logic        SNES_reset_n;
  logic        pad_latch;

  modport master (
    output SNES_CPU_CLK_in, SNES_READ_in, SNES_WRITE_in, SNES_PARD_in,
           SNES_PAWR_in, SNES_RESET_in, SNES_ADDR, SNES_DATA,
    input  SNES_cycle_start, SNES_rd_strobe, SNES_wr_strobe, SNES_wr_end,
           SNES_pard_strobe, SNES_pawr_strobe, SNES_reset_strobe,
           SNES_reset_n, pad_latch
  );

  modport slave (
    input  SNES_CPU_CLK_in, SNES_READ_in, SNES_WRITE_in, SNES_PARD_in,
           SNES_PAWR_in, SNES_RESET_in, SNES_ADDR, SNES_DATA,
    output SNES_cycle_start, SNES_rd_strobe, SNES_wr_strobe, SNES_wr_end,
           SNES_pard_strobe, SNES_pawr_strobe, SNES_reset_strobe,
           SNES_reset_n, pad_latch
  );

endinterface

// File: rtl/snes_sig_filter.sv
// One async pin: 2-flop sync, FILT_LEN-sample glitch filter, registered rise/fall pulses.
// Latency raw edge -> pulse is 2 + FILT_LEN + 1 cycles; no backpressure.
module snes_sig_filter
  import snes_bus_pkg::*;
#(
  parameter int   FILT_LEN = FILT_LEN_DEFAULT,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] CNT_MAX = 3'(FILT_LEN - 1);

  logic       s1, s2;
  logic       level_d;
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= RST_VAL;
      s2      <= RST_VAL;
      level   <= RST_VAL;
      level_d <= RST_VAL;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // cnt holds how many consecutive samples already disagreed with level
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

endmodule

// File: rtl/snes_bus_sync.sv
// Conditions raw SNES control pins into clk-domain strobes and tracks manual $4016 pad latching per frame.
// Strobes lag raw edges by 2 + FILT_LEN + 1 cycles; pad_latch updates 1 cycle after the NMI-vector read; no backpressure.
module snes_bus_sync
  import snes_bus_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  snes_bus_sync_if.slave bus
);

  logic [9:0] unused_sig;
  logic       unused_wd;

  snes_sig_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b0)) u_cpu_clk (
    .clk(clk), .rst_n(rst_n), .raw(bus.SNES_CPU_CLK_in),
    .level(unused_sig[0]), .rise(bus.SNES_cycle_start), .fall(unused_sig[1])
  );

  snes_sig_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_rd (
    .clk(clk), .rst_n(rst_n), .raw(bus.SNES_READ_in),
    .level(unused_sig[2]), .rise(unused_sig[3]), .fall(bus.SNES_rd_strobe)
  );

  snes_sig_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_wr (
    .clk(clk), .rst_n(rst_n), .raw(bus.SNES_WRITE_in),
    .level(unused_sig[4]), .rise(bus.SNES_wr_end), .fall(bus.SNES_wr_strobe)
  );

  snes_sig_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_pard (
    .clk(clk), .rst_n(rst_n), .raw(bus.SNES_PARD_in),
    .level(unused_sig[5]), .rise(unused_sig[6]), .fall(bus.SNES_pard_strobe)
  );

  snes_sig_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_pawr (
    .clk(clk), .rst_n(rst_n), .raw(bus.SNES_PAWR_in),
    .level(unused_sig[7]), .rise(unused_sig[8]), .fall(bus.SNES_pawr_strobe)
  );

  snes_sig_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_reset (
    .clk(clk), .rst_n(rst_n), .raw(bus.SNES_RESET_in),
    .level(bus.SNES_reset_n), .rise(unused_sig[9]), .fall(bus.SNES_reset_strobe)
  );

  logic [23:0] wa;
  logic [7:0]  wd;
  logic        latch_hi;
  logic        acc;
  logic        pad_latch_q;
  logic        wa_hit;
  logic        acc_set;
  logic        nmi_rd;

  assign unused_wd     = ^wd[7:1];
  assign bus.pad_latch = pad_latch_q;

  always_comb begin
    wa_hit  = is_lowbank(wa[23:16]) && (wa[15:0] == PAD_LATCH_ADDR);
    acc_set = bus.SNES_wr_end && wa_hit && !wd[0] && latch_hi;
    nmi_rd  = bus.SNES_rd_strobe && (bus.SNES_ADDR == NMI_VEC_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wa          <= '0;
      wd          <= '0;
      latch_hi    <= 1'b0;
      acc         <= 1'b0;
      pad_latch_q <= 1'b0;
    end else begin
      if (bus.SNES_wr_strobe) begin
        wa <= bus.SNES_ADDR;
        wd <= bus.SNES_DATA;
      end
      if (bus.SNES_reset_strobe) begin
        latch_hi    <= 1'b0;
        acc         <= 1'b0;
        pad_latch_q <= 1'b0;
      end else begin
        // A 1 arms the latch; a following 0 completes the strobe pair.
        if (bus.SNES_wr_end && wa_hit)
          latch_hi <= wd[0];
        if (nmi_rd) begin
          pad_latch_q <= acc | acc_set;
          acc         <= 1'b0;
        end else if (acc_set) begin
          acc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snes_bus_sync.sv
// Directed + randomized bench for snes_bus_sync; strobes and pad_latch checked every cycle against a pulse-level model.
module tb_snes_bus_sync;

  localparam int          MAXC = 8000;
  localparam logic [5:0]  IDLE = 6'b111110;
  localparam logic [5:0]  M_CPU = 6'b000001, M_RD = 6'b000010, M_WR = 6'b000100;
  localparam logic [5:0]  M_PARD = 6'b001000, M_PAWR = 6'b010000, M_RST = 6'b100000;
  localparam logic [23:0] NMI = 24'h00FFEA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  pins = IDLE;
  logic [23:0] addr = '0;
  logic [7:0]  data = '0;

  snes_bus_sync_if bus ();

  assign bus.SNES_CPU_CLK_in = pins[0];
  assign bus.SNES_READ_in    = pins[1];
  assign bus.SNES_WRITE_in   = pins[2];
  assign bus.SNES_PARD_in    = pins[3];
  assign bus.SNES_PAWR_in    = pins[4];
  assign bus.SNES_RESET_in   = pins[5];
  assign bus.SNES_ADDR       = addr;
  assign bus.SNES_DATA       = data;

  snes_bus_sync #(.FILT_LEN(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [6:0] exp_strb [MAXC];
  int         pad_change_cyc = -1;
  logic       pad_new = 1'b0;
  logic       exp_pad = 1'b0;
  logic       m_hi = 1'b0;
  logic       m_acc = 1'b0;
  int         last_cs = -1;
  int         cs_period = 0;

  function automatic logic lowbank(input logic [23:0] a);
    int bank;
    bank = int'(a[23:16]);
    return (bank <= 'h3F) || (bank >= 'h80 && bank <= 'hBF);
  endfunction

  task automatic sched(input int c, input int b);
    if (c < MAXC) exp_strb[c][b] = 1'b1;
  endtask

  task automatic tick();
    logic [6:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      fails++;
      $display("FAIL cycle_budget exceeded at cyc=%0d limit=%0d", cyc, MAXC);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "cycle budget exhausted");
    end
    if (cyc == pad_change_cyc) exp_pad = pad_new;
    obs = {bus.SNES_reset_strobe, bus.SNES_pawr_strobe, bus.SNES_pard_strobe,
           bus.SNES_wr_end, bus.SNES_wr_strobe, bus.SNES_rd_strobe, bus.SNES_cycle_start};
    tests++;
    assert (obs === exp_strb[cyc]) else begin
      fails++;
      $error("FAIL strobes cyc=%0d observed=%b expected=%b", cyc, obs, exp_strb[cyc]);
    end
    tests++;
    assert (bus.pad_latch === exp_pad) else begin
      fails++;
      $error("FAIL pad_latch cyc=%0d observed=%b expected=%b", cyc, bus.pad_latch, exp_pad);
    end
    if (bus.SNES_cycle_start === 1'b1) begin
      if (last_cs >= 0) cs_period = cyc - last_cs;
      last_cs = cyc;
    end
  endtask

  // Drive the pins in mask to their active level for w cycles, then idle for gap cycles.
  task automatic pulse(input logic [5:0] mask, input int w, input int gap);
    int k;
    k = cyc;
    pins = pins ^ mask;
    if (w >= 3) begin
      if (mask[0]) sched(k + 6, 0);
      if (mask[1]) sched(k + 6, 1);
      if (mask[2]) sched(k + 6, 2);
      if (mask[2]) sched(k + w + 6, 3);
      if (mask[3]) sched(k + 6, 4);
      if (mask[4]) sched(k + 6, 5);
      if (mask[5]) sched(k + 6, 6);
      if (mask[2] && lowbank(addr) && addr[15:0] == 16'h4016) begin
        if (data[0]) m_hi = 1'b1;
        else if (m_hi) begin
          m_acc = 1'b1;
          m_hi  = 1'b0;
        end
      end
      if (mask[1] && addr == NMI) begin
        pad_change_cyc = k + 7;
        pad_new        = m_acc;
        m_acc          = 1'b0;
      end
      if (mask[5]) begin
        pad_change_cyc = k + 7;
        pad_new        = 1'b0;
        m_acc          = 1'b0;
        m_hi           = 1'b0;
      end
    end
    repeat (w) tick();
    if (mask[5] && w >= 5) begin
      tests++;
      assert (bus.SNES_reset_n === 1'b0) else begin
        fails++;
        $error("FAIL reset_n_low observed=%b expected=0", bus.SNES_reset_n);
      end
    end
    pins = pins ^ mask;
    repeat (gap) tick();
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    pulse(M_WR, 4, 8);
  endtask

  task automatic check_pad(input string tag, input logic want);
    tests++;
    assert (bus.pad_latch === want) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.pad_latch, want);
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) exp_strb[i] = '0;

    // Reset state
    repeat (3) tick();
    tests++;
    assert (bus.SNES_reset_n === 1'b1) else begin
      fails++;
      $error("FAIL reset_n_in_reset observed=%b expected=1", bus.SNES_reset_n);
    end
    rst_n = 1'b1;
    repeat (10) tick();

    // Clean /RD low for 10 cycles, then /WR glitches of 2 and 3 cycles
    addr = 24'h001234;
    pulse(M_RD, 10, 8);
    pulse(M_WR, 2, 8);
    pulse(M_WR, 3, 8);

    // $4016 latch pair followed by NMI reads
    bus_write(24'h004016, 8'h01);
    bus_write(24'h004016, 8'h00);
    addr = NMI;
    pulse(M_RD, 4, 8);
    check_pad("pad_after_latch_pair", 1'b1);
    pulse(M_RD, 4, 8);
    check_pad("pad_second_nmi", 1'b0);

    // Same offset in bank $7E does not decode
    bus_write(24'h7E4016, 8'h01);
    bus_write(24'h7E4016, 8'h00);
    addr = NMI;
    pulse(M_RD, 4, 8);
    check_pad("pad_bank_7e", 1'b0);

    // Console /RESET mid-frame after a latch pair
    bus_write(24'h804016, 8'h01);
    bus_write(24'h804016, 8'h00);
    addr = NMI;
    pulse(M_RD, 4, 8);
    check_pad("pad_bank_80", 1'b1);
    bus_write(24'h004016, 8'h01);
    bus_write(24'h004016, 8'h00);
    pulse(M_RST, 10, 8);
    check_pad("pad_after_reset", 1'b0);
    tests++;
    assert (bus.SNES_reset_n === 1'b1) else begin
      fails++;
      $error("FAIL reset_n_released observed=%b expected=1", bus.SNES_reset_n);
    end
    addr = NMI;
    pulse(M_RD, 4, 8);
    check_pad("pad_nmi_after_reset", 1'b0);

    // Simultaneous B-bus events
    pulse(M_PARD | M_PAWR, 4, 8);

    // Random pulses on any subset of the non-reset pins
    for (int i = 0; i < 60; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(1, 31));
      addr = 24'($urandom);
      if (addr == NMI) addr = 24'h000000;
      data = 8'($urandom);
      pulse({1'b0, r}, $urandom_range(1, 6), $urandom_range(3, 8));
    end
    repeat (12) tick();

    // rst_n during an active /WR with CPU_CLK toggling
    pins[2] = 1'b0;
    pins[0] = 1'b1;
    tick();
    pins[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    pins[0] = 1'b1;
    exp_pad = 1'b0;
    pad_change_cyc = -1;
    m_acc = 1'b0;
    m_hi = 1'b0;
    tick();
    tests++;
    assert (bus.SNES_reset_n === 1'b1) else begin
      fails++;
      $error("FAIL reset_n_rst_mid observed=%b expected=1", bus.SNES_reset_n);
    end
    pins[0] = 1'b0;
    tick();
    pins[0] = 1'b1;
    tick();
    pins = IDLE;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // CPU clock at ~3.58 MHz: 27 clk period
    last_cs = -1;
    cs_period = 0;
    repeat (6) pulse(M_CPU, 13, 14);
    tests++;
    assert (cs_period == 27) else begin
      fails++;
      $error("FAIL cycle_start_period observed=%0d expected=27", cs_period);
    end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
